// File: rtl/sample_walker_pkg.sv
// Shared raster-walk definitions: walker states, MSAA one-hot codes and the
// step-shift helper used by the step decoder.
package sample_walker_pkg;

   typedef enum logic [0:0] {
      StWait,
      StTest
   } walk_state_e;

   localparam logic [3:0] MSAA_1X  = 4'b1000;
   localparam logic [3:0] MSAA_4X  = 4'b0100;
   localparam logic [3:0] MSAA_16X = 4'b0010;
   localparam logic [3:0] MSAA_64X = 4'b0001;

   // Each MSAA level halves the sample pitch; malformed codes fall back to 1x.
   function automatic int unsigned step_shift(input int unsigned radix,
                                              input logic [3:0]  code);
      int unsigned shift;
      case (code)
         MSAA_4X:  shift = radix - 1;
         MSAA_16X: shift = radix - 2;
         MSAA_64X: shift = radix - 3;
         default:  shift = radix;
      endcase
      return shift;
   endfunction

endpackage

// File: rtl/sample_step_dec.sv
// Combinational decode of the one-hot MSAA mode into a fixed-point sample step.
module sample_step_dec
   import sample_walker_pkg::*;
#(
   parameter int unsigned SIGFIG = 24,
   parameter int unsigned RADIX  = 10
) (
   input  logic [3:0]        subsample_i,
   output logic [SIGFIG-1:0] step_o
);

   always_comb begin
      step_o = SIGFIG'(1) << step_shift(RADIX, subsample_i);
   end

endmodule

// File: rtl/sample_walker.sv
// Raster-order sample iterator: latches one triangle and its grid-aligned box,
// then emits one sample location per cycle while stalling the bbox stage.
module sample_walker
   import sample_walker_pkg::*;
#(
   parameter int unsigned SIGFIG = 24,
   parameter int unsigned RADIX  = 10,
   parameter int unsigned VERTS  = 3,
   parameter int unsigned AXIS   = 3,
   parameter int unsigned COLORS = 3
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
   input  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
   input  logic [1:0][1:0][SIGFIG-1:0]            box_R14S,
   input  logic                                   validTri_R14H,
   input  logic [3:0]                             subSample_RnnnnU,
   output logic                                   halt_RnnnnH,
   output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
   output logic [COLORS-1:0][SIGFIG-1:0]          color_R16U,
   output logic [1:0][SIGFIG-1:0]                 sample_R16S,
   output logic                                   validSamp_R16H
);

   walk_state_e                            state_q, state_d;
   logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
   logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
   logic [1:0][1:0][SIGFIG-1:0]            box_q, box_d;
   logic [1:0][SIGFIG-1:0]                 sample_q, sample_d;
   logic [SIGFIG-1:0]                      step_q, step_d, step_dec;
   logic                                   valid_q, valid_d;
   logic                                   box_legal, at_right, at_top;

   sample_step_dec #(
      .SIGFIG(SIGFIG),
      .RADIX (RADIX)
   ) u_step_dec (
      .subsample_i(subSample_RnnnnU),
      .step_o     (step_dec)
   );

   // Box index [0]=lower-left, [1]=upper-right; coordinate index [0]=x, [1]=y.
   assign box_legal = ($signed(box_R14S[0][0]) <= $signed(box_R14S[1][0])) &&
                      ($signed(box_R14S[0][1]) <= $signed(box_R14S[1][1]));
   assign at_right  = (sample_q[0] == box_q[1][0]);
   assign at_top    = (sample_q[1] == box_q[1][1]);

   always_comb begin
      state_d  = state_q;
      tri_d    = tri_q;
      color_d  = color_q;
      box_d    = box_q;
      step_d   = step_q;
      sample_d = sample_q;
      valid_d  = valid_q;
      case (state_q)
         StWait: begin
            valid_d = 1'b0;
            // Illegal boxes are consumed here simply by not leaving StWait.
            if (validTri_R14H && box_legal) begin
               tri_d    = tri_R14S;
               color_d  = color_R14U;
               box_d    = box_R14S;
               step_d   = step_dec;
               sample_d = box_R14S[0];
               valid_d  = 1'b1;
               state_d  = StTest;
            end
         end
         StTest: begin
            if (at_right && at_top) begin
               valid_d = 1'b0;
               state_d = StWait;
            end else if (at_right) begin
               sample_d[0] = box_q[0][0];
               sample_d[1] = sample_q[1] + step_q;
            end else begin
               sample_d[0] = sample_q[0] + step_q;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = StWait;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StWait;
         tri_q    <= '0;
         color_q  <= '0;
         box_q    <= '0;
         step_q   <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         tri_q    <= tri_d;
         color_q  <= color_d;
         box_q    <= box_d;
         step_q   <= step_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
      end
   end

   assign halt_RnnnnH    = (state_q == StTest);
   assign tri_R16S       = tri_q;
   assign color_R16U     = color_q;
   assign sample_R16S    = sample_q;
   assign validSamp_R16H = valid_q;

endmodule

// File: tb/tb_sample_walker.sv
// Directed self-checking bench for sample_walker: raster order, MSAA steps,
// illegal boxes, back-to-back triangles and asynchronous reset.
module tb_sample_walker;

   typedef logic [2:0][2:0][23:0] tri_t;
   typedef logic [2:0][23:0]      col_t;
   typedef logic [1:0][1:0][23:0] box_t;

   localparam logic [3:0] S1X = 4'b1000;
   localparam logic [3:0] S4X = 4'b0100;

   logic           clk = 1'b0;
   logic           rst;
   tri_t           tri_in;
   col_t           col_in;
   box_t           box_in;
   logic           vtri;
   logic [3:0]     sub_in;
   logic           halt;
   tri_t           tri_out;
   col_t           col_out;
   logic [1:0][23:0] sample;
   logic           vsamp;

   int checks = 0;
   int errors = 0;

   int   sx_q[$];
   int   sy_q[$];
   tri_t tr_q[$];
   col_t co_q[$];
   bit   vt_q[$];
   int   halt_cnt;
   int   hv_bad;

   sample_walker dut (
      .clk             (clk),
      .rst             (rst),
      .tri_R14S        (tri_in),
      .color_R14U      (col_in),
      .box_R14S        (box_in),
      .validTri_R14H   (vtri),
      .subSample_RnnnnU(sub_in),
      .halt_RnnnnH     (halt),
      .tri_R16S        (tri_out),
      .color_R16U      (col_out),
      .sample_R16S     (sample),
      .validSamp_R16H  (vsamp)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      vt_q.push_back(vsamp);
      if (halt !== vsamp) hv_bad++;
      if (halt === 1'b1) halt_cnt++;
      if (vsamp === 1'b1) begin
         sx_q.push_back(int'($signed(sample[0])));
         sy_q.push_back(int'($signed(sample[1])));
         tr_q.push_back(tri_out);
         co_q.push_back(col_out);
      end
   end

   function automatic tri_t mk_tri(input int seed);
      tri_t r;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) r[i][j] = 24'(seed * 100 + i * 10 + j);
      return r;
   endfunction

   function automatic col_t mk_col(input int seed);
      col_t r;
      for (int i = 0; i < 3; i++) r[i] = 24'(seed * 1000 + 7 * i + 1);
      return r;
   endfunction

   function automatic box_t mk_box(input int llx, input int lly, input int urx, input int ury);
      box_t r;
      r[0][0] = 24'(llx);
      r[0][1] = 24'(lly);
      r[1][0] = 24'(urx);
      r[1][1] = 24'(ury);
      return r;
   endfunction

   task automatic clear_rec();
      sx_q.delete();
      sy_q.delete();
      tr_q.delete();
      co_q.delete();
      vt_q.delete();
      halt_cnt = 0;
      hv_bad   = 0;
   endtask

   // Presents a triangle and holds it until halt is low again; optionally
   // flips subSample every halted cycle. Starts and ends at posedge+1.
   task automatic send(input tri_t t, input col_t c, input box_t b,
                       input logic [3:0] sub, input logic [3:0] alt, input bit toggle);
      bit done = 0;
      tri_in = t;
      col_in = c;
      box_in = b;
      sub_in = sub;
      vtri   = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(posedge clk);
         #1;
         if (halt !== 1'b1) done = 1;
         else if (toggle) sub_in = (sub_in == sub) ? alt : sub;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_timeout: halt still %b after 200 cycles, required 0", halt);
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      tri_in = mk_tri(9);
      col_in = mk_col(9);
      box_in = mk_box(0, 0, 1024, 1024);
      sub_in = S1X;
      vtri   = 1'b1;
      #12;
      checks++;
      if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b required 0", halt); end
      checks++;
      if (vsamp !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", vsamp); end
      checks++;
      if (sample !== '0) begin errors++; $display("FAIL reset_sample: got %h required 0", sample); end
      checks++;
      if (tri_out !== '0) begin errors++; $display("FAIL reset_tri: got %h required 0", tri_out); end
      checks++;
      if (col_out !== '0) begin errors++; $display("FAIL reset_color: got %h required 0", col_out); end
      vtri = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_1x();
      int   ex[6] = '{0, 1024, 2048, 0, 1024, 2048};
      int   ey[6] = '{0, 0, 0, 1024, 1024, 1024};
      tri_t t = mk_tri(1);
      col_t c = mk_col(1);
      clear_rec();
      send(t, c, mk_box(0, 0, 2048, 1024), S1X, S1X, 1'b0);
      vtri = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (sx_q.size() != 6) begin
         errors++; $display("FAIL 1x_count: got %0d samples required 6", sx_q.size());
      end
      for (int i = 0; i < sx_q.size() && i < 6; i++) begin
         checks++;
         if (sx_q[i] !== ex[i] || sy_q[i] !== ey[i]) begin
            errors++;
            $display("FAIL 1x_sample%0d: got (%0d,%0d) required (%0d,%0d)",
                     i, sx_q[i], sy_q[i], ex[i], ey[i]);
         end
         checks++;
         if (tr_q[i] !== t || co_q[i] !== c) begin
            errors++; $display("FAIL 1x_tri_color%0d: got %h/%h required %h/%h",
                               i, tr_q[i], co_q[i], t, c);
         end
      end
      checks++;
      if (halt_cnt !== 6) begin errors++; $display("FAIL 1x_halt_cycles: got %0d required 6", halt_cnt); end
      checks++;
      if (hv_bad !== 0) begin errors++; $display("FAIL 1x_halt_vs_valid: got %0d required 0", hv_bad); end
   endtask

   task automatic test_4x();
      int   ex[4] = '{512, 1024, 512, 1024};
      int   ey[4] = '{512, 512, 1024, 1024};
      tri_t t = mk_tri(2);
      col_t c = mk_col(2);
      clear_rec();
      send(t, c, mk_box(512, 512, 1024, 1024), S4X, S4X, 1'b0);
      vtri = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (sx_q.size() != 4) begin
         errors++; $display("FAIL 4x_count: got %0d samples required 4", sx_q.size());
      end
      for (int i = 0; i < sx_q.size() && i < 4; i++) begin
         checks++;
         if (sx_q[i] !== ex[i] || sy_q[i] !== ey[i]) begin
            errors++;
            $display("FAIL 4x_sample%0d: got (%0d,%0d) required (%0d,%0d)",
                     i, sx_q[i], sy_q[i], ex[i], ey[i]);
         end
      end
      checks++;
      if (halt_cnt !== 4) begin errors++; $display("FAIL 4x_halt_cycles: got %0d required 4", halt_cnt); end
   endtask

   task automatic test_single();
      tri_t t = mk_tri(3);
      col_t c = mk_col(3);
      clear_rec();
      send(t, c, mk_box(3072, 2048, 3072, 2048), S1X, S1X, 1'b0);
      vtri = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (sx_q.size() != 1) begin
         errors++; $display("FAIL single_count: got %0d samples required 1", sx_q.size());
      end else begin
         checks++;
         if (sx_q[0] !== 3072 || sy_q[0] !== 2048) begin
            errors++; $display("FAIL single_sample: got (%0d,%0d) required (3072,2048)",
                               sx_q[0], sy_q[0]);
         end
      end
      checks++;
      if (halt_cnt !== 1) begin errors++; $display("FAIL single_halt_cycles: got %0d required 1", halt_cnt); end
      checks++;
      if (halt !== 1'b0) begin errors++; $display("FAIL single_back_to_wait: halt %b required 0", halt); end
   endtask

   task automatic test_illegal();
      bit   ev[4] = '{0, 0, 1, 0};
      tri_t t = mk_tri(5);
      clear_rec();
      send(mk_tri(4), mk_col(4), mk_box(2048, 0, 1024, 0), S1X, S1X, 1'b0);
      send(t, mk_col(5), mk_box(0, 0, 0, 0), S1X, S1X, 1'b0);
      vtri = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (vt_q.size() != 4) begin
         errors++; $display("FAIL illegal_trace_len: got %0d required 4", vt_q.size());
      end
      for (int i = 0; i < vt_q.size() && i < 4; i++) begin
         checks++;
         if (vt_q[i] !== ev[i]) begin
            errors++; $display("FAIL illegal_valid_cycle%0d: got %b required %b", i, vt_q[i], ev[i]);
         end
      end
      checks++;
      if (halt_cnt !== 1) begin errors++; $display("FAIL illegal_halt_cycles: got %0d required 1", halt_cnt); end
      if (tr_q.size() > 0) begin
         checks++;
         if (tr_q[0] !== t) begin
            errors++; $display("FAIL illegal_tri: got %h required %h", tr_q[0], t);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit   ev[8] = '{0, 1, 1, 0, 1, 1, 0, 0};
      int   ex[4] = '{0, 1024, 0, 512};
      int   ey[4] = '{0, 0, 2048, 2048};
      tri_t t0 = mk_tri(6);
      tri_t t1 = mk_tri(7);
      clear_rec();
      send(t0, mk_col(6), mk_box(0, 0, 1024, 0), S1X, S4X, 1'b1);
      send(t1, mk_col(7), mk_box(0, 2048, 512, 2048), S4X, S1X, 1'b1);
      vtri = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (vt_q.size() != 8) begin
         errors++; $display("FAIL b2b_trace_len: got %0d required 8", vt_q.size());
      end
      for (int i = 0; i < vt_q.size() && i < 8; i++) begin
         checks++;
         if (vt_q[i] !== ev[i]) begin
            errors++; $display("FAIL b2b_valid_cycle%0d: got %b required %b", i, vt_q[i], ev[i]);
         end
      end
      for (int i = 0; i < sx_q.size() && i < 4; i++) begin
         checks++;
         if (sx_q[i] !== ex[i] || sy_q[i] !== ey[i] || tr_q[i] !== ((i < 2) ? t0 : t1)) begin
            errors++;
            $display("FAIL b2b_sample%0d: got (%0d,%0d) tri %h required (%0d,%0d) tri %h",
                     i, sx_q[i], sy_q[i], tr_q[i], ex[i], ey[i], (i < 2) ? t0 : t1);
         end
      end
   endtask

   task automatic test_async_reset();
      tri_t t = mk_tri(8);
      clear_rec();
      tri_in = mk_tri(10);
      col_in = mk_col(10);
      box_in = mk_box(0, 0, 2048, 1024);
      sub_in = S1X;
      vtri   = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst  = 1'b1;
      vtri = 1'b0;
      #1;
      checks++;
      if (vsamp !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b required 0", vsamp); end
      checks++;
      if (halt !== 1'b0) begin errors++; $display("FAIL arst_halt: got %b required 0", halt); end
      checks++;
      if (sample !== '0 || tri_out !== '0) begin
         errors++; $display("FAIL arst_data: got %h/%h required 0/0", sample, tri_out);
      end
      checks++;
      if (sx_q.size() != 2) begin
         errors++; $display("FAIL arst_pre_count: got %0d samples required 2", sx_q.size());
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_rec();
      send(t, mk_col(8), mk_box(1024, 0, 2048, 0), S1X, S1X, 1'b0);
      vtri = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (sx_q.size() != 2) begin
         errors++; $display("FAIL arst_post_count: got %0d samples required 2", sx_q.size());
      end else begin
         checks++;
         if (sx_q[0] !== 1024 || sy_q[0] !== 0 || sx_q[1] !== 2048 || tr_q[0] !== t) begin
            errors++; $display("FAIL arst_restart: got (%0d,%0d),(%0d,%0d) required (1024,0),(2048,0)",
                               sx_q[0], sy_q[0], sx_q[1], sy_q[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_1x();
      test_4x();
      test_single();
      test_illegal();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_walker.md
Name: sample_walker

Overview:
- Raster-iteration stage directly upstream of the sample test stage.
- Accepts one triangle per transaction from the bounding-box stage: vertices, color, and a bounding box already snapped to the sample grid.
- Walks every sample location inside the box in raster order, presenting one (triangle, color, sample, valid) tuple per cycle to the sample test stage.
- Stalls the bounding-box stage through a halt signal while iterating.

Parameters:
SIGFIG, 24, bits in color and position
RADIX, 10, fraction bits in position
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
tri_R14S  in  VERTS x AXIS x SIGFIG signed  triangle from bbox stage
color_R14U  in  COLORS x SIGFIG unsigned  triangle color
box_R14S  in  2 x 2 x SIGFIG signed  [0]=lower-left (x,y), [1]=upper-right (x,y), grid-aligned
validTri_R14H  in  1  triangle/box valid
subSample_RnnnnU  in  4  one-hot MSAA mode: 4'b1000=1x, 0100=4x, 0010=16x, 0001=64x
halt_RnnnnH  out  1  high: bbox stage must hold its current triangle
tri_R16S  out  VERTS x AXIS x SIGFIG signed  latched triangle
color_R16U  out  COLORS x SIGFIG unsigned  latched color
sample_R16S  out  2 x SIGFIG signed  current sample (x,y)
validSamp_R16H  out  1  sample_R16S is a valid sample of the current triangle

Behaviour:
- Reset values: state=WAIT, halt_RnnnnH=0, validSamp_R16H=0, sample/tri/color/latched box all 0.
- Reset mid-iteration: the in-flight triangle is dropped, with no further valid samples.
- All outputs are registered. halt_RnnnnH is decoded from the state register only: high iff state==TEST.
- Step decode, by subSample one-hot:
  - 1000 -> step = 1<<RADIX
  - 0100 -> step = 1<<(RADIX-1)
  - 0010 -> step = 1<<(RADIX-2)
  - 0001 -> step = 1<<(RADIX-3)
  - Any non-one-hot code is treated as 1x.
  - The step is latched at acceptance; later changes to subSample do not affect the triangle in flight.
- WAIT state:
  - If validTri_R14H=1 and the box is legal (ll_x<=ur_x and ll_y<=ur_y, signed compare): latch tri, color, box and step; sample<=ll; validSamp<=1; state->TEST.
  - If validTri_R14H=1 and the box is illegal: the triangle is consumed and discarded; state stays WAIT; validSamp stays 0.
  - Otherwise validSamp<=0.
- TEST state, evaluated each cycle on the current sample:
  - at_right = (sample_x == ur_x); at_top = (sample_y == ur_y).
  - at_right && at_top: validSamp<=0, state->WAIT (last sample was shown this cycle).
  - at_right only: sample_x<=ll_x, sample_y<=sample_y+step.
  - Otherwise: sample_x<=sample_x+step.
  - tri/color outputs are held constant for the whole triangle.
- Timing: a box of W x H samples gives exactly W*H consecutive cycles of validSamp=1. halt is high during exactly those cycles.
- There is one bubble cycle (WAIT) between consecutive triangles. The next triangle is accepted in that WAIT cycle.
- Arithmetic: SIGFIG-bit signed add. Boxes are screen-bounded and grid-aligned, so no overflow. Equality compares provide termination; there is no overshoot handling.
- Upstream contract: validTri_R14H and its data are held stable while halt=1. Any validTri seen while halt=1 is ignored.
- No downstream backpressure: the sample test stage consumes one sample per cycle unconditionally.

Decomposition:
- Shared raster package:
  - state enum typedef {WAIT, TEST}
  - MSAA one-hot code constants (MSAA_1X, MSAA_4X, MSAA_16X, MSAA_64X)
  - step-shift function of RADIX
- One sub-module: sample_step_dec (one-hot subSample -> step value, combinational). The FSM, counters and output registers stay in sample_walker.

Test Plan:
- 1x, RADIX=10, box ll=(0,0) ur=(2048,1024) -> 6 valid samples in order (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024); halt high exactly those 6 cycles; tri/color constant.
- 4x, box ll=(512,512) ur=(1024,1024) -> samples (512,512),(1024,512),(512,1024),(1024,1024); step 512.
- Single-sample box ll=ur=(3072,2048) -> exactly 1 valid cycle, 1 halt cycle, then WAIT.
- Illegal box ll_x=2048 > ur_x=1024 with validTri=1 -> zero valid samples, halt stays 0, next legal triangle accepted the next cycle.
- Two triangles back-to-back, 2-sample boxes each, validTri held while halt=1 -> samples T0,T0,bubble,T1,T1; the second triangle is not accepted twice; subSample toggled mid-triangle has no effect.
- rst asserted asynchronously on the 3rd sample of a 6-sample box -> validSamp and halt drop immediately without waiting for a clock edge; after release, state=WAIT and a new triangle starts from its ll corner.
